// File: rtl/ecc_scrubber_if.sv
// Memory port and external SECDED decoder port used by the scrubber.
// The master side is the scrubber. The slave side is the memory/decoder.
interface ecc_scrubber_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [31:0]       mem_rd_data;
   logic              mem_wr_en;
   logic [31:0]       mem_wr_data;
   logic [31:0]       ecc_in;
   logic [31:0]       ecc_out;
   logic              ecc_err2;

   modport master (
      output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, ecc_in,
      input  mem_rd_data, ecc_out, ecc_err2
   );

   modport slave (
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, ecc_in,
      output mem_rd_data, ecc_out, ecc_err2
   );
endinterface

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: reads each word once per pass and checks it through an external SECDED decoder.
// It writes back single-error corrections and records double-error words.
module ecc_scrubber #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               hold,
   output logic               busy,
   output logic               done,
   ecc_scrubber_if.master     bus,
   output logic [15:0]        corr_cnt,
   output logic [15:0]        uncorr_cnt,
   output logic [ADDR_W-1:0]  err_addr,
   output logic               err_valid
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WRITE, FINISH} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       word;
   logic [31:0]       wr_data;
   logic              rd_en, wr_en, last, fix;

   assign last = (addr == LAST);
   // A clean-but-different decoder output means a correctable single-bit error
   assign fix  = !bus.ecc_err2 && (bus.ecc_out != word);

   assign bus.mem_addr    = addr;
   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_wr_en   = wr_en;
   assign bus.mem_wr_data = wr_data;
   assign bus.ecc_in      = word;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = READ;
         READ: begin
            busy = 1'b1;
            if (!hold) begin
               rd_en     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            busy      = 1'b1;
            state_nxt = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            if (fix)       state_nxt = WRITE;
            else if (last) state_nxt = FINISH;
            else           state_nxt = READ;
         end
         WRITE: begin
            busy      = 1'b1;
            wr_en     = 1'b1;
            state_nxt = last ? FINISH : READ;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr       <= '0;
         word       <= '0;
         wr_data    <= '0;
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
         err_addr   <= '0;
         err_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               addr       <= '0;
               corr_cnt   <= '0;
               uncorr_cnt <= '0;
               err_addr   <= '0;
               err_valid  <= 1'b0;
            end
            WAIT: word <= bus.mem_rd_data;
            CHECK: begin
               if (bus.ecc_err2) begin
                  if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
                  if (!err_valid) begin
                     err_addr  <= addr;
                     err_valid <= 1'b1;
                  end
               end else if (fix) begin
                  wr_data <= bus.ecc_out;
               end
               if (!fix && !last) addr <= addr + 1'b1;
            end
            WRITE: begin
               if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
               if (!last) addr <= addr + 1'b1;
            end
            FINISH: addr <= '0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed, table-driven bench for ecc_scrubber with a 4-word memory and a behavioural SECDED decoder.
module tb_ecc_scrubber;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;
   localparam logic [31:0] SGL = 32'h0000_0100;
   localparam logic [31:0] DBL = 32'h0000_0300;

   logic clk, rst, start, hold, busy, done, err_valid;
   logic [15:0] corr_cnt, uncorr_cnt;
   logic [ADDR_W-1:0] err_addr;

   ecc_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

   ecc_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .busy(busy), .done(done), .bus(bus),
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
      .err_addr(err_addr), .err_valid(err_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] good [DEPTH];
   logic [31:0] mem  [DEPTH];
   int total = 0, bad = 0;
   int wr_count = 0, rdwr_overlap = 0, hold_rd = 0;
   logic [ADDR_W-1:0] last_wa;
   logic [31:0] last_wd;

   // Memory with one-cycle read latency, plus protocol monitors
   initial bus.mem_rd_data = '0;
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
      if (bus.mem_wr_en) begin
         mem[bus.mem_addr] = bus.mem_wr_data;
         wr_count++;
         last_wa = bus.mem_addr;
         last_wd = bus.mem_wr_data;
      end
      if (bus.mem_rd_en && bus.mem_wr_en) rdwr_overlap++;
      if (bus.mem_rd_en && hold) hold_rd++;
   end

   // Decoder: one flipped bit is corrected; the two-bit pattern is flagged uncorrectable
   always_comb begin
      bus.ecc_out  = bus.ecc_in;
      bus.ecc_err2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.ecc_in == (good[i] ^ SGL)) bus.ecc_out = good[i];
         if (bus.ecc_in == (good[i] ^ DBL)) bus.ecc_err2 = 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      bit          flip2;
      bit          dbl13;
      int          hold_len;
      bit          restart;
      int          exp_cyc;
      int          exp_corr;
      int          exp_uncorr;
      bit          exp_ev;
      int          exp_ea;
      int          exp_wr;
      int          exp_wa;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs [5];

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = good[i];
         if (v.flip2 && i == 2) mem[i] = good[i] ^ SGL;
         if (v.dbl13 && (i == 1 || i == 3)) mem[i] = good[i] ^ DBL;
      end
   endtask

   task automatic run_pass(input vec_t v);
      int cyc, hold_left, busy_after;
      bit got, hold_used;
      load_mem(v);
      wr_count = 0; rdwr_overlap = 0; hold_rd = 0;
      cyc = -1; got = 0; hold_used = 0; hold_left = 0; busy_after = 0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc >= 0) cyc++;
         else if (busy) cyc = 0;
         if (v.restart && cyc == 3) start = 1'b1;
         if (done) begin
            got = 1;
            if (v.restart) start = 1'b1;
         end
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) hold = 1'b0;
         end else if (!hold_used && v.hold_len > 0 && busy && bus.mem_addr == 1) begin
            hold = 1'b1;
            hold_left = v.hold_len;
            hold_used = 1;
         end
      end
      chk({v.name, " done_seen"}, 128'(got), 128'(1));
      @(negedge clk);
      start = 1'b0;
      hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (busy) busy_after++;
      end
      chk({v.name, " cycles"},     128'(cyc),        128'(v.exp_cyc));
      chk({v.name, " corr_cnt"},   128'(corr_cnt),   128'(v.exp_corr));
      chk({v.name, " uncorr_cnt"}, 128'(uncorr_cnt), 128'(v.exp_uncorr));
      chk({v.name, " err_valid"},  128'(err_valid),  128'(v.exp_ev));
      chk({v.name, " err_addr"},   128'(err_addr),   128'(v.exp_ea));
      chk({v.name, " writes"},     128'(wr_count),   128'(v.exp_wr));
      chk({v.name, " rd_wr_overlap"}, 128'(rdwr_overlap), 128'(0));
      chk({v.name, " rd_during_hold"}, 128'(hold_rd), 128'(0));
      chk({v.name, " no_second_pass"}, 128'(busy_after), 128'(0));
      chk({v.name, " hold_applied"}, 128'(hold_used), 128'(v.hold_len > 0));
      if (v.exp_wr > 0) begin
         chk({v.name, " wr_addr"}, 128'(last_wa), 128'(v.exp_wa));
         chk({v.name, " wr_data"}, 128'(last_wd), 128'(v.exp_wd));
         chk({v.name, " mem_fixed"}, 128'(mem[2]), 128'(good[2]));
      end
   endtask

   initial begin
      int w0;
      bit seen;
      good[0] = 32'h1111_0000; good[1] = 32'h2222_0001;
      good[2] = 32'h3333_0002; good[3] = 32'h4444_0003;
      for (int i = 0; i < DEPTH; i++) mem[i] = good[i];
      //            name       flip dbl hold rst cyc corr unc ev ea wr wa wd
      vecs[0] = '{"clean",     0,   0,  0,   0,  12, 0,   0,  0, 0, 0, 0, 32'h0};
      vecs[1] = '{"single",    1,   0,  0,   0,  13, 1,   0,  0, 0, 1, 2, 32'h3333_0002};
      vecs[2] = '{"double",    0,   1,  0,   0,  12, 0,   2,  1, 1, 0, 0, 32'h0};
      vecs[3] = '{"hold",      0,   0,  5,   0,  17, 0,   0,  0, 0, 0, 0, 32'h0};
      vecs[4] = '{"restart",   0,   0,  0,   1,  12, 0,   0,  0, 0, 0, 0, 32'h0};

      rst = 1'b1; start = 1'b0; hold = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state",
          {busy, done, bus.mem_rd_en, bus.mem_wr_en, err_valid, corr_cnt, uncorr_cnt,
           bus.mem_addr, err_addr, bus.mem_wr_data, bus.ecc_in}, 128'(0));
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_pass(vecs[i]);

      // Reset landing on the WRITE cycle of addr 2
      load_mem(vecs[1]);
      seen = 0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (bus.mem_wr_en && bus.mem_addr == 2) seen = 1;
      end
      chk("midwrite_reached", 128'(seen), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("midwrite_reset_outputs",
          {busy, done, bus.mem_rd_en, bus.mem_wr_en, err_valid, corr_cnt, uncorr_cnt,
           bus.mem_addr, err_addr, bus.mem_wr_data, bus.ecc_in}, 128'(0));
      rst = 1'b0;
      w0 = wr_count;
      repeat (5) @(negedge clk);
      chk("no_write_after_reset", 128'(wr_count), 128'(w0));
      chk("idle_after_reset", 128'(busy), 128'(0));
      run_pass(vecs[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ecc_scrubber.md
ECC_SCRUBBER -- requirements
Module: ecc_scrubber

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DEPTH, default 256, number of words scrubbed per pass (DEPTH <= 2**ADDR_W).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a scrub pass; ignored while busy=1.
REQ-006 hold  input  1  host-priority stall; while high, the scrubber issues no new memory read.
REQ-007 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-008 done  output  1  one-cycle pulse when a pass completes.
REQ-009 mem_addr  output  ADDR_W  word address for read and write.
REQ-010 mem_rd_en  output  1  read strobe; memory returns data exactly 1 cycle later.
REQ-011 mem_rd_data  input  32  read codeword.
REQ-012 mem_wr_en  output  1  write strobe for a corrected word.
REQ-013 mem_wr_data  output  32  corrected codeword.
REQ-014 ecc_in  output  32  codeword driven to the external combinational SECDED decoder.
REQ-015 ecc_out  input  32  decoder-corrected codeword, valid in the same cycle as ecc_in.
REQ-016 ecc_err2  input  1  decoder double-error flag, valid in the same cycle as ecc_in.
REQ-017 corr_cnt  output  16  count of corrected (single-error) words in the current/last pass.
REQ-018 uncorr_cnt  output  16  count of double-error words in the current/last pass.
REQ-019 err_addr  output  ADDR_W  address of the first double-error word in the current/last pass.
REQ-020 err_valid  output  1  sticky; high once err_addr holds a captured address.

Function
REQ-021 The FSM SHALL have the states IDLE, READ, WAIT, CHECK, WRITE and FINISH.
REQ-022 IDLE: on start=1, clear addr, corr_cnt, uncorr_cnt, err_addr and err_valid, assert busy, and go to READ.
REQ-023 READ: if hold=1, stay in READ with mem_rd_en=0; else assert mem_rd_en=1 with mem_addr=addr for one cycle and go to WAIT.
REQ-024 WAIT: capture mem_rd_data into an internal word register; go to CHECK; hold is ignored.
REQ-025 CHECK: drive ecc_in from the captured register and sample ecc_out and ecc_err2 in the same cycle.
REQ-026 CHECK, ecc_err2=1: increment uncorr_cnt; if err_valid=0, set err_addr=addr and err_valid=1; perform no write; go to NEXT handling (REQ-029).
REQ-027 CHECK, ecc_err2=0 and ecc_out != captured word: register ecc_out into mem_wr_data; go to WRITE.
REQ-028 CHECK, ecc_err2=0 and ecc_out == captured word: no write; go to NEXT handling.
REQ-029 WRITE: assert mem_wr_en=1 for exactly one cycle with mem_addr=addr; increment corr_cnt; then apply NEXT handling; hold is ignored.
REQ-030 NEXT handling, performed in the same transition: if addr == DEPTH-1, go to FINISH; else set addr=addr+1 and go to READ.
REQ-031 FINISH: pulse done=1 for one cycle, drop busy in the same cycle, set addr=0, and go to IDLE.
REQ-032 Per-word latency: 3 cycles for a clean or double-error word and 4 for a corrected word, excluding hold stalls.
REQ-033 corr_cnt and uncorr_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-034 Counters, err_addr and err_valid SHALL hold their values after done until the next accepted start.
REQ-035 mem_rd_en and mem_wr_en SHALL never be asserted in the same cycle.
REQ-036 A start pulse in any state other than IDLE, including FINISH, SHALL be ignored.
REQ-037 ecc_in SHALL reflect the captured word register in all states.

Reset
REQ-038 When rst=1 at a clock edge, the FSM SHALL enter IDLE, regardless of state, including mid-pass or mid-WRITE.
REQ-039 On that edge, busy, done, mem_rd_en, mem_wr_en, err_valid, corr_cnt and uncorr_cnt SHALL go to 0.
REQ-040 On that edge, mem_addr, err_addr, mem_wr_data and the word register SHALL go to 0.
REQ-041 A reset mid-pass SHALL abandon any pending write: no mem_wr_en is asserted after the reset edge.

Verification
REQ-042 DEPTH=4, all words clean, start pulse: done 12 cycles after the first READ cycle; corr_cnt=0, uncorr_cnt=0, err_valid=0; no mem_wr_en.
REQ-043 Word 2 has a single-bit error and the decoder returns the corrected value: exactly one mem_wr_en with mem_addr=2 and mem_wr_data=corrected word; corr_cnt=1; done after 13 cycles.
REQ-044 Words 1 and 3 return ecc_err2=1: uncorr_cnt=2, err_addr=1, err_valid=1; no writes.
REQ-045 hold=1 for 5 cycles while in READ at addr 1: no mem_rd_en during the hold; pass completes 5 cycles later than in REQ-042 with identical results.
REQ-046 rst asserted in the WRITE cycle of addr 2: all outputs return to 0 on the next edge; a new start then completes a full pass with counters starting from 0.
REQ-047 start pulsed while busy=1, and again in the FINISH cycle: both pulses are ignored; the pass is unaffected and no second pass starts.
